// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and state encoding for the memory/write-back stage.
package mem_wb_stage_pkg;

    localparam int DATA_W          = 32;
    localparam int REG_W           = 5;
    localparam int CNT_W           = 8;
    localparam int MEM_TIMEOUT_DEF = 16;
    localparam int RA_REG_DEF      = 31;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } memState_e;

endpackage

// File: rtl/mem_wb_stage_branch_resolve.sv
// Combinational branch/jump resolution: taken decision and redirect target.
module mem_wb_stage_branch_resolve
    import mem_wb_stage_pkg::*;
(
    input  logic              zero,
    input  logic              jump,
    input  logic              branchEq,
    input  logic              branchNe,
    input  logic [DATA_W-1:0] jumpAddress,
    input  logic [DATA_W-1:0] branchAddress,
    output logic              take,
    output logic [DATA_W-1:0] target
);

    logic taken;

    assign taken  = (branchEq & zero) | (branchNe & ~zero);
    assign take   = jump | taken;
    // Jump wins over a simultaneously taken branch.
    assign target = jump ? jumpAddress : branchAddress;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: branch redirect, data-memory handshake with timeout,
// and the registered write-back bundle for the register file.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int RA_REG      = RA_REG_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_Zero,
    input  logic [DATA_W-1:0] in_ALUResult,
    input  logic [DATA_W-1:0] in_ReadData2,
    input  logic [DATA_W-1:0] in_JumpAddress,
    input  logic [DATA_W-1:0] in_BranchAddress,
    input  logic [DATA_W-1:0] in_PC_4,
    input  logic              in_CtrlJump,
    input  logic              in_CtrlMemRead,
    input  logic              in_CtrlMemWrite,
    input  logic              in_CtrlALUOrMem,
    input  logic              in_CtrlBranchEquals,
    input  logic              in_CtrlBranchNotEquals,
    input  logic              in_CtrlRegisterOrPC,
    input  logic              in_CtrlALUMemOrPC,
    input  logic              in_CtrlRegWrite,
    input  logic [REG_W-1:0]  in_WriteReg,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              out_Stall,
    output logic              out_PCRedirect,
    output logic [DATA_W-1:0] out_PCTarget,
    output logic              out_Flush,
    output logic [DATA_W-1:0] out_WriteData,
    output logic [REG_W-1:0]  out_WriteReg,
    output logic              out_RegWrite,
    output logic              out_MemError
);

    localparam logic [REG_W-1:0] RaReg     = REG_W'(RA_REG);
    localparam logic [CNT_W-1:0] TimeoutTc = CNT_W'(MEM_TIMEOUT - 1);

    memState_e        state, nextState;
    logic [CNT_W-1:0] waitCnt;
    logic             memOp, aligned, illegalRw, timeoutHit, errorThisOp;
    logic             branchTake;

    assign memOp       = in_CtrlMemRead | in_CtrlMemWrite;
    assign aligned     = (in_ALUResult[1:0] == 2'b00);
    assign illegalRw   = in_CtrlMemRead & in_CtrlMemWrite;
    assign timeoutHit  = (state == MEM_WAIT) && (waitCnt == TimeoutTc);
    assign errorThisOp = (memOp & (~aligned | illegalRw)) | timeoutHit;

    assign mem_we    = in_CtrlMemWrite;
    assign mem_addr  = in_ALUResult;
    assign mem_wdata = in_ReadData2;

    mem_wb_stage_branch_resolve uBranch (
        .zero          (in_Zero),
        .jump          (in_CtrlJump),
        .branchEq      (in_CtrlBranchEquals),
        .branchNe      (in_CtrlBranchNotEquals),
        .jumpAddress   (in_JumpAddress),
        .branchAddress (in_BranchAddress),
        .take          (branchTake),
        .target        (out_PCTarget)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MEM_IDLE;
            waitCnt <= '0;
        end else begin
            state <= nextState;
            if (state == MEM_IDLE) waitCnt <= '0;
            else                   waitCnt <= waitCnt + 1'b1;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            MEM_IDLE: if (mem_req && !mem_ready)     nextState = MEM_WAIT;
            MEM_WAIT: if (mem_ready || timeoutHit)   nextState = MEM_IDLE;
            default:                                 nextState = MEM_IDLE;
        endcase
    end

    // Upstream holds the op stable while stalled, so WAIT keeps the request up
    // until either completion or the timeout cycle, where it is dropped.
    always_comb begin
        mem_req = 1'b0;
        case (state)
            MEM_IDLE: mem_req = memOp & aligned;
            MEM_WAIT: mem_req = ~timeoutHit;
            default:  mem_req = 1'b0;
        endcase
        if (reset) mem_req = 1'b0;
        out_Stall      = mem_req & ~mem_ready;
        out_PCRedirect = branchTake & ~out_Stall & ~reset;
        out_Flush      = out_PCRedirect;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_WriteData <= '0;
            out_WriteReg  <= '0;
            out_RegWrite  <= 1'b0;
            out_MemError  <= 1'b0;
        end else if (out_Stall) begin
            out_RegWrite <= 1'b0;
        end else begin
            out_MemError  <= out_MemError | errorThisOp;
            out_WriteData <= in_CtrlALUMemOrPC ? in_PC_4 :
                             (in_CtrlALUOrMem ? mem_rdata : in_ALUResult);
            out_WriteReg  <= in_CtrlRegisterOrPC ? RaReg : in_WriteReg;
            out_RegWrite  <= in_CtrlRegWrite & ~errorThisOp;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (built with MEM_TIMEOUT=4).
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_Zero;
    logic [31:0] in_ALUResult, in_ReadData2, in_JumpAddress, in_BranchAddress, in_PC_4;
    logic        in_CtrlJump, in_CtrlMemRead, in_CtrlMemWrite, in_CtrlALUOrMem;
    logic        in_CtrlBranchEquals, in_CtrlBranchNotEquals, in_CtrlRegisterOrPC;
    logic        in_CtrlALUMemOrPC, in_CtrlRegWrite;
    logic [4:0]  in_WriteReg;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        out_Stall, out_PCRedirect, out_Flush, out_RegWrite, out_MemError;
    logic [31:0] out_PCTarget, out_WriteData;
    logic [4:0]  out_WriteReg;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.MEM_TIMEOUT(4), .RA_REG(31)) dut (
        .clk(clk), .reset(reset), .in_Zero(in_Zero), .in_ALUResult(in_ALUResult),
        .in_ReadData2(in_ReadData2), .in_JumpAddress(in_JumpAddress),
        .in_BranchAddress(in_BranchAddress), .in_PC_4(in_PC_4),
        .in_CtrlJump(in_CtrlJump), .in_CtrlMemRead(in_CtrlMemRead),
        .in_CtrlMemWrite(in_CtrlMemWrite), .in_CtrlALUOrMem(in_CtrlALUOrMem),
        .in_CtrlBranchEquals(in_CtrlBranchEquals), .in_CtrlBranchNotEquals(in_CtrlBranchNotEquals),
        .in_CtrlRegisterOrPC(in_CtrlRegisterOrPC), .in_CtrlALUMemOrPC(in_CtrlALUMemOrPC),
        .in_CtrlRegWrite(in_CtrlRegWrite), .in_WriteReg(in_WriteReg),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .out_Stall(out_Stall),
        .out_PCRedirect(out_PCRedirect), .out_PCTarget(out_PCTarget), .out_Flush(out_Flush),
        .out_WriteData(out_WriteData), .out_WriteReg(out_WriteReg),
        .out_RegWrite(out_RegWrite), .out_MemError(out_MemError)
    );

    task automatic clear_inputs();
        in_Zero = 0; in_ALUResult = 0; in_ReadData2 = 0; in_JumpAddress = 0;
        in_BranchAddress = 0; in_PC_4 = 0; in_CtrlJump = 0; in_CtrlMemRead = 0;
        in_CtrlMemWrite = 0; in_CtrlALUOrMem = 0; in_CtrlBranchEquals = 0;
        in_CtrlBranchNotEquals = 0; in_CtrlRegisterOrPC = 0; in_CtrlALUMemOrPC = 0;
        in_CtrlRegWrite = 0; in_WriteReg = 0; mem_rdata = 0; mem_ready = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk); clear_inputs(); reset = 1;
        @(posedge clk); @(negedge clk); reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); clear_inputs(); reset = 1;
        in_CtrlMemRead = 1; in_ALUResult = 32'h100; in_CtrlJump = 1;
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got=%0b exp=0", mem_req); end
        vectors++; if (out_Stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got=%0b exp=0", out_Stall); end
        vectors++; if (out_PCRedirect !== 1'b0) begin miscompares++; $display("FAIL rst_redirect got=%0b exp=0", out_PCRedirect); end
        @(posedge clk); @(posedge clk); #1;
        vectors++; if (out_WriteData !== 32'h0) begin miscompares++; $display("FAIL rst_wdata got=%0h exp=0", out_WriteData); end
        vectors++; if (out_WriteReg !== 5'd0) begin miscompares++; $display("FAIL rst_wreg got=%0d exp=0", out_WriteReg); end
        vectors++; if (out_RegWrite !== 1'b0) begin miscompares++; $display("FAIL rst_regwrite got=%0b exp=0", out_RegWrite); end
        vectors++; if (out_MemError !== 1'b0) begin miscompares++; $display("FAIL rst_memerr got=%0b exp=0", out_MemError); end
        @(negedge clk); clear_inputs(); reset = 0;
    endtask

    task automatic test_alu_op();
        @(negedge clk); clear_inputs();
        in_ALUResult = 32'h1234; in_CtrlRegWrite = 1; in_WriteReg = 5'd8;
        #1;
        vectors++; if (out_Stall !== 1'b0) begin miscompares++; $display("FAIL alu_stall got=%0b exp=0", out_Stall); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL alu_mem_req got=%0b exp=0", mem_req); end
        @(posedge clk); #1;
        vectors++; if (out_WriteData !== 32'h1234) begin miscompares++; $display("FAIL alu_wdata got=%0h exp=1234", out_WriteData); end
        vectors++; if (out_WriteReg !== 5'd8) begin miscompares++; $display("FAIL alu_wreg got=%0d exp=8", out_WriteReg); end
        vectors++; if (out_RegWrite !== 1'b1) begin miscompares++; $display("FAIL alu_regwrite got=%0b exp=1", out_RegWrite); end
    endtask

    typedef struct { logic jmp, beq, bne, zero; logic [31:0] target; logic redirect; } brVec_t;

    task automatic test_branch();
        brVec_t vecs[5];
        vecs[0] = '{jmp:0, beq:1, bne:0, zero:1, target:32'h40, redirect:1};
        vecs[1] = '{jmp:0, beq:0, bne:1, zero:1, target:32'h40, redirect:0};
        vecs[2] = '{jmp:0, beq:0, bne:1, zero:0, target:32'h40, redirect:1};
        vecs[3] = '{jmp:0, beq:1, bne:0, zero:0, target:32'h40, redirect:0};
        vecs[4] = '{jmp:1, beq:1, bne:0, zero:1, target:32'h80, redirect:1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); clear_inputs();
            in_BranchAddress = 32'h40; in_JumpAddress = 32'h80;
            in_CtrlJump = vecs[i].jmp; in_CtrlBranchEquals = vecs[i].beq;
            in_CtrlBranchNotEquals = vecs[i].bne; in_Zero = vecs[i].zero;
            #1;
            vectors++; if (out_PCRedirect !== vecs[i].redirect) begin miscompares++; $display("FAIL br%0d_redirect got=%0b exp=%0b", i, out_PCRedirect, vecs[i].redirect); end
            vectors++; if (out_Flush !== vecs[i].redirect) begin miscompares++; $display("FAIL br%0d_flush got=%0b exp=%0b", i, out_Flush, vecs[i].redirect); end
            if (vecs[i].redirect) begin
                vectors++; if (out_PCTarget !== vecs[i].target) begin miscompares++; $display("FAIL br%0d_target got=%0h exp=%0h", i, out_PCTarget, vecs[i].target); end
            end
        end
    endtask

    task automatic test_load();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); clear_inputs();
            in_CtrlMemRead = 1; in_CtrlALUOrMem = 1; in_CtrlRegWrite = 1;
            in_WriteReg = 5'd5; in_ALUResult = 32'h100; in_CtrlJump = 1;
            mem_ready = (c == 3); mem_rdata = (c == 3) ? 32'hDEADBEEF : 32'h0;
            #1;
            vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL ld%0d_mem_req got=%0b exp=1", c, mem_req); end
            vectors++; if (out_Stall !== (c != 3)) begin miscompares++; $display("FAIL ld%0d_stall got=%0b exp=%0b", c, out_Stall, c != 3); end
            vectors++; if (out_PCRedirect !== (c == 3)) begin miscompares++; $display("FAIL ld%0d_redirect got=%0b exp=%0b", c, out_PCRedirect, c == 3); end
            vectors++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin miscompares++; $display("FAIL ld%0d_addr got=%0h/%0b exp=100/0", c, mem_addr, mem_we); end
            @(posedge clk); #1;
            if (c < 3) begin
                vectors++; if (out_RegWrite !== 1'b0) begin miscompares++; $display("FAIL ld%0d_bubble got=%0b exp=0", c, out_RegWrite); end
            end
        end
        vectors++; if (out_WriteData !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ld_wdata got=%0h exp=deadbeef", out_WriteData); end
        vectors++; if (out_RegWrite !== 1'b1 || out_WriteReg !== 5'd5) begin miscompares++; $display("FAIL ld_wb got=%0b/%0d exp=1/5", out_RegWrite, out_WriteReg); end
        @(negedge clk); clear_inputs();
        in_CtrlMemRead = 1; in_CtrlALUOrMem = 1; in_CtrlRegWrite = 1; in_WriteReg = 5'd6;
        in_ALUResult = 32'h200; mem_ready = 1; mem_rdata = 32'h55AA;
        #1;
        vectors++; if (out_Stall !== 1'b0 || mem_req !== 1'b1) begin miscompares++; $display("FAIL ld0w_stall got=%0b/%0b exp=0/1", out_Stall, mem_req); end
        @(posedge clk); #1;
        vectors++; if (out_WriteData !== 32'h55AA || out_RegWrite !== 1'b1) begin miscompares++; $display("FAIL ld0w_wb got=%0h/%0b exp=55aa/1", out_WriteData, out_RegWrite); end
    endtask

    task automatic test_jal();
        @(negedge clk); clear_inputs();
        in_CtrlJump = 1; in_CtrlALUMemOrPC = 1; in_CtrlRegisterOrPC = 1; in_CtrlRegWrite = 1;
        in_PC_4 = 32'h20; in_WriteReg = 5'd3; in_JumpAddress = 32'h400; in_ALUResult = 32'h999;
        #1;
        vectors++; if (out_PCRedirect !== 1'b1 || out_PCTarget !== 32'h400) begin miscompares++; $display("FAIL jal_redirect got=%0b/%0h exp=1/400", out_PCRedirect, out_PCTarget); end
        @(posedge clk); #1;
        vectors++; if (out_WriteReg !== 5'd31) begin miscompares++; $display("FAIL jal_wreg got=%0d exp=31", out_WriteReg); end
        vectors++; if (out_WriteData !== 32'h20) begin miscompares++; $display("FAIL jal_wdata got=%0h exp=20", out_WriteData); end
        vectors++; if (out_RegWrite !== 1'b1) begin miscompares++; $display("FAIL jal_regwrite got=%0b exp=1", out_RegWrite); end
    endtask

    task automatic test_timeout();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); clear_inputs();
            in_CtrlMemRead = 1; in_CtrlALUOrMem = 1; in_CtrlRegWrite = 1;
            in_WriteReg = 5'd9; in_ALUResult = 32'h300;
            #1;
            vectors++; if (out_Stall !== (c < 4)) begin miscompares++; $display("FAIL to%0d_stall got=%0b exp=%0b", c, out_Stall, c < 4); end
            vectors++; if (mem_req !== (c < 4)) begin miscompares++; $display("FAIL to%0d_mem_req got=%0b exp=%0b", c, mem_req, c < 4); end
            @(posedge clk); #1;
        end
        vectors++; if (out_RegWrite !== 1'b0) begin miscompares++; $display("FAIL to_regwrite got=%0b exp=0", out_RegWrite); end
        vectors++; if (out_MemError !== 1'b1) begin miscompares++; $display("FAIL to_memerr got=%0b exp=1", out_MemError); end
        @(negedge clk); clear_inputs(); #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL to_idle_req got=%0b exp=0", mem_req); end
    endtask

    task automatic test_illegal_rw();
        apply_reset();
        @(negedge clk); clear_inputs();
        in_CtrlMemRead = 1; in_CtrlMemWrite = 1; in_CtrlRegWrite = 1; in_WriteReg = 5'd4;
        in_ALUResult = 32'h10; in_ReadData2 = 32'hCAFE; mem_ready = 1;
        #1;
        vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hCAFE) begin miscompares++; $display("FAIL rw_store got=%0b/%0b/%0h exp=1/1/cafe", mem_req, mem_we, mem_wdata); end
        @(posedge clk); #1;
        vectors++; if (out_MemError !== 1'b1 || out_RegWrite !== 1'b0) begin miscompares++; $display("FAIL rw_err got=%0b/%0b exp=1/0", out_MemError, out_RegWrite); end
    endtask

    task automatic test_misaligned();
        apply_reset();
        @(negedge clk); clear_inputs();
        in_CtrlMemWrite = 1; in_CtrlRegWrite = 1; in_WriteReg = 5'd7; in_ALUResult = 32'h102;
        mem_ready = 1;
        #1;
        vectors++; if (mem_req !== 1'b0 || out_Stall !== 1'b0) begin miscompares++; $display("FAIL mis_req got=%0b/%0b exp=0/0", mem_req, out_Stall); end
        @(posedge clk); #1;
        vectors++; if (out_MemError !== 1'b1 || out_RegWrite !== 1'b0) begin miscompares++; $display("FAIL mis_err got=%0b/%0b exp=1/0", out_MemError, out_RegWrite); end
        @(negedge clk); clear_inputs();
        in_ALUResult = 32'h77; in_CtrlRegWrite = 1; in_WriteReg = 5'd2;
        @(posedge clk); #1;
        vectors++; if (out_MemError !== 1'b1 || out_RegWrite !== 1'b1) begin miscompares++; $display("FAIL mis_sticky got=%0b/%0b exp=1/1", out_MemError, out_RegWrite); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        @(negedge clk); clear_inputs();
        in_CtrlMemRead = 1; in_CtrlALUOrMem = 1; in_CtrlRegWrite = 1; in_ALUResult = 32'h100;
        @(posedge clk);
        @(negedge clk); #1;
        vectors++; if (out_Stall !== 1'b1) begin miscompares++; $display("FAIL rmw_wait_stall got=%0b exp=1", out_Stall); end
        reset = 1; #1;
        vectors++; if (mem_req !== 1'b0 || out_Stall !== 1'b0) begin miscompares++; $display("FAIL rmw_forced got=%0b/%0b exp=0/0", mem_req, out_Stall); end
        @(posedge clk);
        @(negedge clk); clear_inputs(); reset = 0; mem_ready = 1; mem_rdata = 32'hBAD; #1;
        vectors++; if (mem_req !== 1'b0 || out_Stall !== 1'b0) begin miscompares++; $display("FAIL rmw_idle got=%0b/%0b exp=0/0", mem_req, out_Stall); end
        vectors++; if (out_RegWrite !== 1'b0 || out_WriteData !== 32'h0 || out_MemError !== 1'b0) begin miscompares++; $display("FAIL rmw_cleared got=%0b/%0h/%0b exp=0/0/0", out_RegWrite, out_WriteData, out_MemError); end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_alu_op();
        test_branch();
        test_load();
        test_jal();
        test_timeout();
        test_illegal_rw();
        test_misaligned();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
